// File: rtl/poly_add_24.sv
// Two-lane streaming modular adder mod Q with valid/ready backpressure.
// Two-stage pipeline (raw sum, then conditional subtract) plus per-polynomial framing.
module poly_add_24 #(
    parameter logic [24:0] Q       = 25'd16515073,
    parameter int unsigned N_PAIRS = 128,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [49:0] din1,
    input  logic [49:0] din2,
    output logic [49:0] dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PAIRS - 1);

    logic             en;
    logic             out_hs;
    logic             s1_valid;
    logic [25:0]      s1_sum1;
    logic [25:0]      s1_sum0;
    logic [CNT_W-1:0] cnt;

    // Canonical operands keep sum <= 2Q-2, so one conditional subtract suffices.
    function automatic logic [24:0] reduce(input logic [25:0] sum);
        logic [25:0] diff;
        diff = sum - {1'b0, Q};
        return (sum >= {1'b0, Q}) ? diff[24:0] : sum[24:0];
    endfunction

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign out_hs   = out_valid && out_ready;
    assign out_last = out_valid && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_sum1   <= '0;
            s1_sum0   <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_sum1 <= {1'b0, din1[49:25]} + {1'b0, din2[49:25]};
                s1_sum0 <= {1'b0, din1[24:0]}  + {1'b0, din2[24:0]};
            end
            if (s1_valid) begin
                dout <= {reduce(s1_sum1), reduce(s1_sum0)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= out_hs && (cnt == LAST);
            if (out_hs) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_poly_add_24.sv
// Bench for poly_add_24: random operand streams checked against a queue-based
// reference of (a+b) mod Q per lane and a handshake-count framing model.
module tb_poly_add_24;

    localparam int unsigned    N_PAIRS = 128;
    localparam longint unsigned QM     = 64'd16515073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [49:0] din1 = '0;
    logic [49:0] din2 = '0;
    logic        in_ready;
    logic [49:0] dout;
    logic        out_valid;
    logic        out_last;
    logic        done;

    poly_add_24 #(.Q(25'd16515073), .N_PAIRS(N_PAIRS), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din1(din1), .din2(din2), .dout(dout), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [49:0]  exp_q[$];
    int unsigned  out_count = 0;
    bit           done_due  = 1'b0;

    // Per-cycle observations and expectations
    logic [49:0] obs_dout, exp_dout;
    logic        obs_ov, obs_ir, obs_last, obs_done;
    logic        in_hs, out_hs, exp_have, exp_last, exp_done;

    function automatic logic [49:0] ref_add(input logic [49:0] a, input logic [49:0] b);
        longint unsigned l1, l0;
        l1 = a[49:25];
        l1 = (l1 + b[49:25]) % QM;
        l0 = a[24:0];
        l0 = (l0 + b[24:0]) % QM;
        return {l1[24:0], l0[24:0]};
    endfunction

    function automatic logic [49:0] rnd();
        logic [24:0] h, l;
        h = 25'($urandom % 32'd16515073);
        l = 25'($urandom % 32'd16515073);
        return {h, l};
    endfunction

    // Drive one cycle (entered at posedge+1), observe at negedge, update model.
    task automatic cycle(input logic iv, input logic [49:0] a, input logic [49:0] b,
                         input logic ordy);
        in_valid = iv; din1 = a; din2 = b; out_ready = ordy;
        @(negedge clk);
        obs_dout = dout; obs_ov = out_valid; obs_ir = in_ready;
        obs_last = out_last; obs_done = done;
        exp_done = done_due;
        done_due = 1'b0;
        in_hs    = iv && obs_ir;
        out_hs   = obs_ov && ordy;
        exp_last = obs_ov && ((out_count % N_PAIRS) == N_PAIRS - 1);
        exp_have = 1'b0;
        exp_dout = 'x;
        if (out_hs) begin
            exp_have = exp_q.size() > 0;
            if (exp_have) exp_dout = exp_q.pop_front();
            if ((out_count % N_PAIRS) == N_PAIRS - 1) done_due = 1'b1;
            out_count++;
        end
        if (in_hs) exp_q.push_back(ref_add(a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        exp_q.delete();
        out_count = 0;
        done_due  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (dout !== '0) $display("FAIL reset_dout: got %0h want 0", dout); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        cycle(1'b1, {25'd5, 25'd100}, {25'd7, 25'd200}, 1'b1);
        n_checks++; if (in_hs !== 1'b1) $display("FAIL single_accept: got %b want 1", in_hs); else n_pass++;
        cycle(1'b0, '0, '0, 1'b1);
        n_checks++; if (obs_ov !== 1'b0) $display("FAIL single_lat1: got %b want 0", obs_ov); else n_pass++;
        cycle(1'b0, '0, '0, 1'b1);
        n_checks++; if (obs_ov !== 1'b1) $display("FAIL single_lat2: got %b want 1", obs_ov); else n_pass++;
        n_checks++;
        if (obs_dout !== {25'd12, 25'd300}) $display("FAIL single_dout: got %0h want %0h", obs_dout, {25'd12, 25'd300});
        else n_pass++;
        cycle(1'b0, '0, '0, 1'b1);
        n_checks++; if (obs_ov !== 1'b0) $display("FAIL single_no_dup: got %b want 0", obs_ov); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [49:0] wa[3], wb[3], wr[3];
        int unsigned k;
        wa[0] = {25'd16515072, 25'd16515072}; wb[0] = {25'd1, 25'd16515072};  wr[0] = {25'd0, 25'd16515071};
        wa[1] = {25'd16515072, 25'd16515072}; wb[1] = {25'd0, 25'd0};         wr[1] = {25'd16515072, 25'd16515072};
        wa[2] = {25'd10000000, 25'd3};        wb[2] = {25'd10000000, 25'd4};  wr[2] = {25'd3484927, 25'd7};
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 3) cycle(1'b1, wa[c], wb[c], 1'b1);
            else       cycle(1'b0, '0, '0, 1'b1);
            if (out_hs && k < 3) begin
                n_checks++;
                if (obs_dout !== wr[k]) $display("FAIL wrap_dout%0d: got %0h want %0h", k, obs_dout, wr[k]);
                else n_pass++;
                k++;
            end
        end
        n_checks++; if (k != 3) $display("FAIL wrap_count: got %0d want 3", k); else n_pass++;
    endtask

    task automatic test_backpressure();
        int unsigned sent, got;
        logic [49:0] pa, pb, prev_dout;
        logic        prev_stall, iv, ordy;
        sent = 0; got = 0; prev_stall = 1'b0; prev_dout = '0;
        pa = rnd(); pb = rnd();
        for (int c = 0; c < 300 && got < 8; c++) begin
            iv   = (sent < 8) && ($urandom % 4 != 0);
            ordy = (c >= 4 && c < 9) ? 1'b0 : 1'($urandom % 2);
            cycle(iv, pa, pb, ordy);
            n_checks++;
            if (obs_ir !== (!obs_ov || ordy)) $display("FAIL bp_in_ready: got %b want %b", obs_ir, !obs_ov || ordy);
            else n_pass++;
            if (prev_stall) begin
                n_checks++;
                if (obs_ov !== 1'b1 || obs_dout !== prev_dout)
                    $display("FAIL bp_stall_hold: got %b/%0h want 1/%0h", obs_ov, obs_dout, prev_dout);
                else n_pass++;
            end
            if (out_hs) begin
                n_checks++;
                if (!exp_have || obs_dout !== exp_dout) $display("FAIL bp_dout%0d: got %0h want %0h", got, obs_dout, exp_dout);
                else n_pass++;
                got++;
            end
            if (in_hs) begin
                sent++; pa = rnd(); pb = rnd();
            end
            prev_stall = obs_ov && !ordy;
            prev_dout  = obs_dout;
        end
        n_checks++; if (got != 8) $display("FAIL bp_count: got %0d want 8", got); else n_pass++;
    endtask

    task automatic test_framing();
        int unsigned sent, got, lasts, dones, total;
        do_reset();
        sent = 0; got = 0; lasts = 0; dones = 0; total = 2 * N_PAIRS + 4;
        for (int c = 0; c < 400 && (got < total || c < total + 4); c++) begin
            cycle(sent < total, rnd(), rnd(), 1'b1);
            n_checks++;
            if (obs_last !== exp_last) $display("FAIL frame_last@%0d: got %b want %b", got, obs_last, exp_last);
            else n_pass++;
            n_checks++;
            if (obs_done !== exp_done) $display("FAIL frame_done@%0d: got %b want %b", got, obs_done, exp_done);
            else n_pass++;
            if (out_hs) begin
                n_checks++;
                if (!exp_have || obs_dout !== exp_dout) $display("FAIL frame_dout%0d: got %0h want %0h", got, obs_dout, exp_dout);
                else n_pass++;
                got++;
            end
            if (in_hs) sent++;
            if (obs_last) lasts++;
            if (obs_done) dones++;
        end
        n_checks++; if (got != total) $display("FAIL frame_count: got %0d want %0d", got, total); else n_pass++;
        n_checks++; if (lasts != 2) $display("FAIL frame_lasts: got %0d want 2", lasts); else n_pass++;
        n_checks++; if (dones != 2) $display("FAIL frame_dones: got %0d want 2", dones); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int unsigned sent, got, lasts, dones, last_at;
        sent = 0;
        for (int c = 0; c < 200 && sent < 50; c++) begin
            cycle(1'b1, rnd(), rnd(), 1'b1);
            if (in_hs) sent++;
        end
        #3 rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (dout !== '0) $display("FAIL mid_dout: got %0h want 0", dout); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL mid_out_last: got %b want 0", out_last); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL mid_done: got %b want 0", done); else n_pass++;
        exp_q.delete();
        out_count = 0;
        done_due  = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        sent = 0; got = 0; lasts = 0; dones = 0; last_at = 0;
        for (int c = 0; c < 300 && (got < N_PAIRS || c < N_PAIRS + 4); c++) begin
            cycle(sent < N_PAIRS, rnd(), rnd(), 1'b1);
            n_checks++;
            if (obs_last !== exp_last) $display("FAIL mid_last@%0d: got %b want %b", got, obs_last, exp_last);
            else n_pass++;
            n_checks++;
            if (obs_done !== exp_done) $display("FAIL mid_done@%0d: got %b want %b", got, obs_done, exp_done);
            else n_pass++;
            if (obs_last) begin
                lasts++; last_at = got;
            end
            if (obs_done) dones++;
            if (out_hs) begin
                n_checks++;
                if (!exp_have || obs_dout !== exp_dout) $display("FAIL mid_dout%0d: got %0h want %0h", got, obs_dout, exp_dout);
                else n_pass++;
                got++;
            end
            if (in_hs) sent++;
        end
        n_checks++; if (lasts != 1) $display("FAIL mid_lasts: got %0d want 1", lasts); else n_pass++;
        n_checks++; if (last_at != N_PAIRS - 1) $display("FAIL mid_last_pos: got %0d want %0d", last_at, N_PAIRS - 1); else n_pass++;
        n_checks++; if (dones != 1) $display("FAIL mid_dones: got %0d want 1", dones); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_framing();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
